escalonador_processos: RTL and testbench

- Round-robin process scheduler and context-switch sequencer for the multiprogrammed processor.
- Each process owns a fixed instruction block of TAM_BLOCO words. The block selects the running process and drives `processo_atual` plus the block base into the branch/PC correction logic.
- Saves and restores each process's logical PC.
- Stalls the core while a switch is in progress.

---
 rtl/escalonador_processos_pkg.sv | 19 +
 rtl/escalonador_processos_seletor.sv | 30 +++
 rtl/escalonador_processos.sv | 137 +++++++++++++
 tb/tb_escalonador_processos.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/escalonador_processos_pkg.sv
// Shared types and constants for the round-robin process scheduler.
package escalonador_pkg;

  typedef enum logic [2:0] {
    OCIOSO,
    EXECUTA,
    SALVA,
    SELECIONA,
    CARREGA
  } estado_t;

  localparam int TAM_BLOCO_PADRAO = 200;
  localparam int QUANTUM_PADRAO   = 16;

  function automatic int pid_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/escalonador_processos_seletor.sv
// Combinational round-robin finder: first set bit of ativo_i at or after inicio_i, wrapping.
module seletor_round_robin
  import escalonador_pkg::*;
#(
  parameter int NUM_PROC = 4,
  localparam int PID_W   = pid_w(NUM_PROC)
) (
  input  logic [NUM_PROC-1:0] ativo_i,
  input  logic [PID_W-1:0]    inicio_i,
  output logic [PID_W-1:0]    id_o,
  output logic                valido_o
);

  logic [PID_W-1:0] idx;

  // Walk from the farthest offset down so the closest active slot wins.
  always_comb begin
    id_o     = '0;
    valido_o = 1'b0;
    idx      = '0;
    for (int k = NUM_PROC - 1; k >= 0; k--) begin
      idx = inicio_i + PID_W'(k);
      if (ativo_i[idx]) begin
        id_o     = idx;
        valido_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/escalonador_processos.sv
// Round-robin scheduler / context-switch sequencer. Define QUANTUM_PREEMPT_EN
// to add quantum-based preemption; otherwise scheduling is cooperative only.
module escalonador_processos
  import escalonador_pkg::*;
#(
  parameter int NUM_PROC  = 4,
  parameter int TAM_BLOCO = TAM_BLOCO_PADRAO,
  parameter int QUANTUM   = QUANTUM_PADRAO,
  parameter int PC_W      = 11,
  localparam int PID_W    = pid_w(NUM_PROC)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             habilita,
  input  logic [PC_W-1:0]  pc_atual,
  input  logic             pedido_troca,
  input  logic             fim_processo,
  input  logic             ativa_proc,
  input  logic [PID_W-1:0] ativa_id,
  output logic [PID_W-1:0] processo_atual,
  output logic [PC_W-1:0]  base_pc,
  output logic [PC_W-1:0]  pc_carregar,
  output logic             carrega_pc,
  output logic             congela,
  output logic             ocioso
);

  if (NUM_PROC < 2 || (NUM_PROC & (NUM_PROC - 1)) != 0) begin : g_chk_np
    $error("NUM_PROC must be a power of two >= 2");
  end
  if (NUM_PROC * TAM_BLOCO > 2 ** PC_W) begin : g_chk_pc
    $error("NUM_PROC*TAM_BLOCO does not fit in PC_W bits");
  end
  if (QUANTUM < 1) begin : g_chk_q
    $error("QUANTUM must be >= 1");
  end

  estado_t                        estado_q, estado_d;
  logic [NUM_PROC-1:0]            ativo_q;
  logic [NUM_PROC-1:0][PC_W-1:0]  tabela_q;
  logic [PID_W-1:0]               proc_q, sel_q, inicio, sel_id;
  logic [PC_W-1:0]                base_q, pcc_q;
  logic                           termina_q, vem_ocioso_q, sel_ok, gatilho, expira;

`ifdef QUANTUM_PREEMPT_EN
  localparam int CNT_W = $clog2(QUANTUM) + 1;
  logic [CNT_W-1:0] cnt_q;

  assign expira = (cnt_q == CNT_W'(QUANTUM - 1));

  always_ff @(posedge clock) begin
    if (reset)                                 cnt_q <= '0;
    else if (estado_q == CARREGA)              cnt_q <= '0;
    else if (estado_q == EXECUTA && habilita)  cnt_q <= cnt_q + 1'b1;
  end
`else
  assign expira = 1'b0;
`endif

  assign gatilho = (estado_q == EXECUTA) && habilita && (pedido_troca || fim_processo || expira);

  // Coming out of idle the search starts at slot 0, not after the stale current ID.
  assign inicio = vem_ocioso_q ? '0 : proc_q + PID_W'(1);

  seletor_round_robin #(.NUM_PROC(NUM_PROC)) u_sel (
    .ativo_i  (ativo_q),
    .inicio_i (inicio),
    .id_o     (sel_id),
    .valido_o (sel_ok)
  );

  always_comb begin
    estado_d = estado_q;
    case (estado_q)
      OCIOSO:    if (|ativo_q) estado_d = SELECIONA;
      EXECUTA:   if (gatilho)  estado_d = SALVA;
      SALVA:     estado_d = SELECIONA;
      SELECIONA: estado_d = sel_ok ? CARREGA : OCIOSO;
      CARREGA:   estado_d = EXECUTA;
      default:   estado_d = OCIOSO;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      estado_q     <= OCIOSO;
      ativo_q      <= '0;
      tabela_q     <= '0;
      proc_q       <= '0;
      sel_q        <= '0;
      base_q       <= '0;
      pcc_q        <= '0;
      termina_q    <= 1'b0;
      vem_ocioso_q <= 1'b1;
    end else begin
      estado_q <= estado_d;
      // Activation overrides the save of the same slot.
      for (int i = 0; i < NUM_PROC; i++) begin
        if (ativa_proc && ativa_id == PID_W'(i)) begin
          ativo_q[i]  <= 1'b1;
          tabela_q[i] <= '0;
        end else if (estado_q == SALVA && proc_q == PID_W'(i)) begin
          if (termina_q) ativo_q[i]  <= 1'b0;
          else           tabela_q[i] <= pc_atual;
        end
      end
      if (gatilho) termina_q <= fim_processo;
      case (estado_q)
        SELECIONA: begin
          if (sel_ok) begin
            sel_q <= sel_id;
            pcc_q <= tabela_q[sel_id];
          end else begin
            termina_q    <= 1'b0;
            vem_ocioso_q <= 1'b1;
          end
        end
        CARREGA: begin
          proc_q       <= sel_q;
          base_q       <= PC_W'(32'(TAM_BLOCO) * 32'(sel_q));
          pcc_q        <= tabela_q[sel_q];
          termina_q    <= 1'b0;
          vem_ocioso_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign processo_atual = proc_q;
  assign base_pc        = base_q;
  assign pc_carregar    = pcc_q;
  assign carrega_pc     = (estado_q == CARREGA);
  assign congela        = (estado_q != EXECUTA);
  assign ocioso         = (estado_q == OCIOSO);

endmodule

// File: tb/tb_escalonador_processos.sv
// Directed bench for escalonador_processos (NUM_PROC=4, TAM_BLOCO=200, QUANTUM=16).
module tb_escalonador_processos;

  logic        clock = 1'b0;
  logic        reset, habilita, pedido_troca, fim_processo, ativa_proc;
  logic [1:0]  ativa_id;
  logic [10:0] pc_atual;
  logic [1:0]  processo_atual;
  logic [10:0] base_pc, pc_carregar;
  logic        carrega_pc, congela, ocioso;

  int n_tests = 0;
  int n_fail  = 0;

  escalonador_processos #(
    .NUM_PROC(4), .TAM_BLOCO(200), .QUANTUM(16), .PC_W(11)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .habilita       (habilita),
    .pc_atual       (pc_atual),
    .pedido_troca   (pedido_troca),
    .fim_processo   (fim_processo),
    .ativa_proc     (ativa_proc),
    .ativa_id       (ativa_id),
    .processo_atual (processo_atual),
    .base_pc        (base_pc),
    .pc_carregar    (pc_carregar),
    .carrega_pc     (carrega_pc),
    .congela        (congela),
    .ocioso         (ocioso)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic quiet_inputs;
    habilita     = 1'b1;
    pedido_troca = 1'b0;
    fim_processo = 1'b0;
    ativa_proc   = 1'b0;
    ativa_id     = 2'd0;
    pc_atual     = 11'd0;
  endtask

  task automatic do_reset;
    quiet_inputs();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic activate(input logic [1:0] id);
    ativa_proc = 1'b1;
    ativa_id   = id;
    tick();
    ativa_proc = 1'b0;
  endtask

  task automatic wait_exec;
    for (int i = 0; i < 20; i++) begin
      if (!congela) return;
      tick();
    end
  endtask

  // Leaves the bench sampling inside the CARREGA cycle.
  task automatic yield_to_carrega(input logic [10:0] pc);
    pc_atual     = pc;
    pedido_troca = 1'b1;
    tick();
    pedido_troca = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_reset;
    quiet_inputs();
    reset      = 1'b1;
    ativa_proc = 1'b1;
    tick();
    tick();
    ativa_proc = 1'b0;
    n_tests++; if (processo_atual !== 2'd0) begin n_fail++; $display("FAIL reset_pid got %0d want 0", processo_atual); end
    n_tests++; if (base_pc !== 11'd0) begin n_fail++; $display("FAIL reset_base got %0d want 0", base_pc); end
    n_tests++; if (pc_carregar !== 11'd0) begin n_fail++; $display("FAIL reset_pcc got %0d want 0", pc_carregar); end
    n_tests++; if (carrega_pc !== 1'b0) begin n_fail++; $display("FAIL reset_carrega got %b want 0", carrega_pc); end
    n_tests++; if (congela !== 1'b1 || ocioso !== 1'b1) begin n_fail++; $display("FAIL reset_flags got congela=%b ocioso=%b want 1 1", congela, ocioso); end
    reset = 1'b0;
  endtask

  task automatic test_first_activation;
    do_reset();
    activate(2'd2);
    n_tests++; if (ocioso !== 1'b1) begin n_fail++; $display("FAIL act_still_idle got %b want 1", ocioso); end
    tick();
    n_tests++; if (congela !== 1'b1 || ocioso !== 1'b0 || carrega_pc !== 1'b0) begin n_fail++; $display("FAIL act_selec got congela=%b ocioso=%b carrega=%b want 1 0 0", congela, ocioso, carrega_pc); end
    tick();
    n_tests++; if (carrega_pc !== 1'b1 || pc_carregar !== 11'd0) begin n_fail++; $display("FAIL act_carrega got carrega=%b pcc=%0d want 1 0", carrega_pc, pc_carregar); end
    tick();
    n_tests++; if (congela !== 1'b0 || carrega_pc !== 1'b0) begin n_fail++; $display("FAIL act_run got congela=%b carrega=%b want 0 0", congela, carrega_pc); end
    n_tests++; if (processo_atual !== 2'd2 || base_pc !== 11'd400) begin n_fail++; $display("FAIL act_pid got pid=%0d base=%0d want 2 400", processo_atual, base_pc); end
  endtask

  task automatic test_yield_restore;
    do_reset();
    activate(2'd0);
    activate(2'd1);
    activate(2'd3);
    wait_exec();
    n_tests++; if (processo_atual !== 2'd0 || congela !== 1'b0) begin n_fail++; $display("FAIL yield_start got pid=%0d congela=%b want 0 0", processo_atual, congela); end
    yield_to_carrega(11'd37);
    n_tests++; if (carrega_pc !== 1'b1 || pc_carregar !== 11'd0) begin n_fail++; $display("FAIL yield_load1 got carrega=%b pcc=%0d want 1 0", carrega_pc, pc_carregar); end
    tick();
    n_tests++; if (processo_atual !== 2'd1 || base_pc !== 11'd200) begin n_fail++; $display("FAIL yield_pid1 got pid=%0d base=%0d want 1 200", processo_atual, base_pc); end
    yield_to_carrega(11'd5);
    tick();
    n_tests++; if (processo_atual !== 2'd3 || base_pc !== 11'd600) begin n_fail++; $display("FAIL yield_pid3 got pid=%0d base=%0d want 3 600", processo_atual, base_pc); end
    yield_to_carrega(11'd9);
    n_tests++; if (carrega_pc !== 1'b1 || pc_carregar !== 11'd37) begin n_fail++; $display("FAIL yield_restore got carrega=%b pcc=%0d want 1 37", carrega_pc, pc_carregar); end
    tick();
    n_tests++; if (processo_atual !== 2'd0 || base_pc !== 11'd0 || pc_carregar !== 11'd37) begin n_fail++; $display("FAIL yield_back0 got pid=%0d base=%0d pcc=%0d want 0 0 37", processo_atual, base_pc, pc_carregar); end
  endtask

`ifdef QUANTUM_PREEMPT_EN
  task automatic test_quantum;
    int cnt;
    do_reset();
    activate(2'd1);
    activate(2'd3);
    wait_exec();
    n_tests++; if (processo_atual !== 2'd1) begin n_fail++; $display("FAIL q_start got pid=%0d want 1", processo_atual); end
    cnt = 0;
    while (!congela && cnt < 100) begin cnt++; tick(); end
    n_tests++; if (cnt !== 16) begin n_fail++; $display("FAIL q_expire got %0d cycles want 16", cnt); end
    wait_exec();
    n_tests++; if (processo_atual !== 2'd3) begin n_fail++; $display("FAIL q_next got pid=%0d want 3", processo_atual); end
    habilita = 1'b0;
    cnt = 0;
    repeat (5) begin if (!congela) cnt++; tick(); end
    habilita = 1'b1;
    while (!congela && cnt < 100) begin cnt++; tick(); end
    n_tests++; if (cnt !== 21) begin n_fail++; $display("FAIL q_frozen got %0d cycles want 21", cnt); end
  endtask
`else
  task automatic test_cooperative;
    int cnt;
    do_reset();
    activate(2'd1);
    activate(2'd3);
    wait_exec();
    n_tests++; if (processo_atual !== 2'd1) begin n_fail++; $display("FAIL coop_start got pid=%0d want 1", processo_atual); end
    cnt = 0;
    while (!congela && cnt < 40) begin cnt++; tick(); end
    n_tests++; if (cnt !== 40) begin n_fail++; $display("FAIL coop_no_preempt got %0d cycles want 40", cnt); end
  endtask
`endif

  task automatic test_terminate;
    do_reset();
    activate(2'd3);
    wait_exec();
    n_tests++; if (processo_atual !== 2'd3) begin n_fail++; $display("FAIL term_start got pid=%0d want 3", processo_atual); end
    fim_processo = 1'b1;
    tick();
    fim_processo = 1'b0;
    tick();
    tick();
    n_tests++; if (ocioso !== 1'b1 || congela !== 1'b1) begin n_fail++; $display("FAIL term_idle got ocioso=%b congela=%b want 1 1", ocioso, congela); end
    tick();
    tick();
    n_tests++; if (ocioso !== 1'b1) begin n_fail++; $display("FAIL term_stays_idle got %b want 1", ocioso); end
    activate(2'd1);
    wait_exec();
    n_tests++; if (processo_atual !== 2'd1 || pc_carregar !== 11'd0 || base_pc !== 11'd200) begin n_fail++; $display("FAIL term_restart got pid=%0d pcc=%0d base=%0d want 1 0 200", processo_atual, pc_carregar, base_pc); end
  endtask

  task automatic test_simultaneous;
    int pulses;
    do_reset();
    activate(2'd0);
    activate(2'd1);
    wait_exec();
    repeat (15) tick();
    fim_processo = 1'b1;
    pedido_troca = 1'b1;
    tick();
    fim_processo = 1'b0;
    pedido_troca = 1'b0;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      pedido_troca = (i == 1);
      if (carrega_pc) pulses++;
      tick();
    end
    pedido_troca = 1'b0;
    n_tests++; if (pulses !== 1) begin n_fail++; $display("FAIL simul_pulses got %0d want 1", pulses); end
    n_tests++; if (processo_atual !== 2'd1 || congela !== 1'b0) begin n_fail++; $display("FAIL simul_pid got pid=%0d congela=%b want 1 0", processo_atual, congela); end
  endtask

  task automatic test_activation_wins;
    do_reset();
    activate(2'd2);
    wait_exec();
    yield_to_carrega(11'd55);
    n_tests++; if (pc_carregar !== 11'd55) begin n_fail++; $display("FAIL solo_reselect got pcc=%0d want 55", pc_carregar); end
    tick();
    fim_processo = 1'b1;
    pc_atual     = 11'd77;
    tick();
    fim_processo = 1'b0;
    ativa_proc   = 1'b1;
    ativa_id     = 2'd2;
    tick();
    ativa_proc = 1'b0;
    tick();
    n_tests++; if (carrega_pc !== 1'b1 || pc_carregar !== 11'd0) begin n_fail++; $display("FAIL wins_load got carrega=%b pcc=%0d want 1 0", carrega_pc, pc_carregar); end
    tick();
    n_tests++; if (processo_atual !== 2'd2 || ocioso !== 1'b0 || congela !== 1'b0) begin n_fail++; $display("FAIL wins_run got pid=%0d ocioso=%b congela=%b want 2 0 0", processo_atual, ocioso, congela); end
    yield_to_carrega(11'd12);
    n_tests++; if (carrega_pc !== 1'b1) begin n_fail++; $display("FAIL rst_mid_in_carrega got %b want 1", carrega_pc); end
    reset = 1'b1;
    tick();
    n_tests++; if (processo_atual !== 2'd0 || base_pc !== 11'd0 || pc_carregar !== 11'd0) begin n_fail++; $display("FAIL rst_mid_regs got pid=%0d base=%0d pcc=%0d want 0 0 0", processo_atual, base_pc, pc_carregar); end
    n_tests++; if (carrega_pc !== 1'b0 || congela !== 1'b1 || ocioso !== 1'b1) begin n_fail++; $display("FAIL rst_mid_flags got carrega=%b congela=%b ocioso=%b want 0 1 1", carrega_pc, congela, ocioso); end
    reset = 1'b0;
    repeat (3) tick();
    n_tests++; if (ocioso !== 1'b1) begin n_fail++; $display("FAIL rst_mid_no_active got ocioso=%b want 1", ocioso); end
  endtask

  initial begin
    quiet_inputs();
    reset = 1'b0;
    test_reset();
    test_first_activation();
    test_yield_restore();
`ifdef QUANTUM_PREEMPT_EN
    test_quantum();
`else
    test_cooperative();
`endif
    test_terminate();
    test_simultaneous();
    test_activation_wins();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
